id_operand_stage: RTL and testbench

Parametrised decode-stage operand fetch for the pipelined CPU: register file, N-deep forwarding network, load-use hazard detection and a registered ID/EX pipeline boundary. It extracts rs/rt/rd/imm16 from the MIPS-format instruction, resolves both source operands against the register file and all in-flight producers, and registers the result for EX. It stalls upstream when a load result is not yet available.

---
 rtl/id_operand_stage.sv | 131 +++++++++++++
 tb/tb_id_operand_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode-stage operand fetch: register file, N-deep forwarding network,
// load-use hazard detection and the registered ID/EX boundary.
module id_operand_stage #(
    parameter int DW     = 32,
    parameter int NREG   = 32,
    parameter int NFWD   = 2,
    parameter int CTRL_W = 12,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          inst,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic                 reg_dst,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [DW-1:0]        wb_data,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD*DW-1:0]   fwd_data,
    input  logic [NFWD-1:0]      fwd_load,
    input  logic                 flush,
    output logic                 stall,
    output logic                 out_valid,
    output logic [DW-1:0]        out_da,
    output logic [DW-1:0]        out_db,
    output logic [15:0]          out_imm16,
    output logic [AW-1:0]        out_rt,
    output logic [AW-1:0]        out_wr_addr,
    output logic [CTRL_W-1:0]    out_ctrl
);

    logic [DW-1:0] rf_reg [NREG];

    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] rd_addr;
    assign rs_addr = inst[21 +: AW];
    assign rt_addr = inst[16 +: AW];
    assign rd_addr = inst[11 +: AW];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            rf_reg[wb_addr] <= wb_data;
        end
    end

    // One resolver per source port: gi=0 is rs (da), gi=1 is rt (db).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam int LSB = (gi == 0) ? 21 : 16;
            logic [AW-1:0] addr;
            logic [DW-1:0] data;
            logic          hazard;

            assign addr = inst[LSB +: AW];

            // Walk oldest to newest so the lowest matching index wins last.
            always_comb begin
                data   = rf_reg[addr];
                hazard = 1'b0;
                if (wb_en && (wb_addr == addr)) begin
                    data = wb_data;
                end
                for (int k = NFWD - 1; k >= 0; k--) begin
                    if (fwd_en[k] && (fwd_addr[k*AW +: AW] == addr)) begin
                        data   = fwd_data[k*DW +: DW];
                        hazard = fwd_load[k];
                    end
                end
                if (addr == '0) begin
                    data   = '0;
                    hazard = 1'b0;
                end
            end
        end
    endgenerate

    logic hazard_any;
    logic accept;
    assign hazard_any = g_port[0].hazard | g_port[1].hazard;
    assign stall      = in_valid & ~flush & hazard_any;
    assign accept     = in_valid & ~flush & ~hazard_any;

    logic                out_valid_reg;
    logic [DW-1:0]       out_da_reg;
    logic [DW-1:0]       out_db_reg;
    logic [15:0]         out_imm16_reg;
    logic [AW-1:0]       out_rt_reg;
    logic [AW-1:0]       out_wr_addr_reg;
    logic [CTRL_W-1:0]   out_ctrl_reg;

    // Bubbles only drop valid; payload holds its last accepted value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_da_reg      <= '0;
            out_db_reg      <= '0;
            out_imm16_reg   <= '0;
            out_rt_reg      <= '0;
            out_wr_addr_reg <= '0;
            out_ctrl_reg    <= '0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            out_da_reg      <= g_port[0].data;
            out_db_reg      <= g_port[1].data;
            out_imm16_reg   <= inst[15:0];
            out_rt_reg      <= rt_addr;
            out_wr_addr_reg <= reg_dst ? rd_addr : rt_addr;
            out_ctrl_reg    <= ctrl_in;
        end else begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_da      = out_da_reg;
    assign out_db      = out_db_reg;
    assign out_imm16   = out_imm16_reg;
    assign out_rt      = out_rt_reg;
    assign out_wr_addr = out_wr_addr_reg;
    assign out_ctrl    = out_ctrl_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed table-driven bench for id_operand_stage: one vector per cycle,
// stall checked before the edge, registered outputs checked after it.
module tb_id_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [31:0]    inst;
    logic [11:0]    ctrl_in;
    logic           reg_dst;
    logic           wb_en;
    logic [AW-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;
    logic [1:0]     fwd_en;
    logic [2*AW-1:0] fwd_addr;
    logic [2*DW-1:0] fwd_data;
    logic [1:0]     fwd_load;
    logic           flush;
    logic           stall;
    logic           out_valid;
    logic [DW-1:0]  out_da;
    logic [DW-1:0]  out_db;
    logic [15:0]    out_imm16;
    logic [AW-1:0]  out_rt;
    logic [AW-1:0]  out_wr_addr;
    logic [11:0]    out_ctrl;

    id_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst),
        .ctrl_in(ctrl_in), .reg_dst(reg_dst), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .fwd_en(fwd_en),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_load(fwd_load),
        .flush(flush), .stall(stall), .out_valid(out_valid),
        .out_da(out_da), .out_db(out_db), .out_imm16(out_imm16),
        .out_rt(out_rt), .out_wr_addr(out_wr_addr), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs, rt, rd;
        logic        rdst;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [1:0]  fe;
        logic [4:0]  fa0;
        logic [31:0] fd0;
        logic [4:0]  fa1;
        logic [31:0] fd1;
        logic [1:0]  fl;
        logic        fsh;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_da;
        logic [31:0] e_db;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    logic [31:0] h_da, h_db;
    logic [15:0] h_imm;
    logic [4:0]  h_rt, h_wr;
    logic [11:0] h_ctrl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic v(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic rdst, input logic wbe,
                     input logic [4:0] wba, input logic [31:0] wbd, input logic [1:0] fe,
                     input logic [4:0] fa0, input logic [31:0] fd0, input logic [4:0] fa1,
                     input logic [31:0] fd1, input logic [1:0] fl, input logic fsh,
                     input logic es, input logic ev, input logic [31:0] eda,
                     input logic [31:0] edb);
        vec_t x;
        x.iv = iv; x.rs = rs; x.rt = rt; x.rd = rd; x.rdst = rdst;
        x.wbe = wbe; x.wba = wba; x.wbd = wbd; x.fe = fe;
        x.fa0 = fa0; x.fd0 = fd0; x.fa1 = fa1; x.fd1 = fd1; x.fl = fl;
        x.fsh = fsh; x.e_stall = es; x.e_valid = ev; x.e_da = eda; x.e_db = edb;
        vecs.push_back(x);
    endtask

    task automatic idle_inputs();
        in_valid = 0; inst = '0; ctrl_in = '0; reg_dst = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0;
        fwd_en = '0; fwd_addr = '0; fwd_data = '0; fwd_load = '0; flush = 0;
    endtask

    initial begin
        logic [10:0] low;
        logic [11:0] ctl;
        rst_n = 1'b0;
        idle_inputs();
        h_da = 0; h_db = 0; h_imm = 0; h_rt = 0; h_wr = 0; h_ctrl = 0;

        //  iv rs rt rd dst wbe wba wbd        fe     fa0 fd0        fa1 fd1        fl     fsh st vl da         db
        v(0, 0, 0, 0, 0,  1, 5, 32'h1234, 2'b00, 0, 0,         0, 0,         2'b00, 0,  0, 0, 0,         0);
        v(1, 5, 0, 9, 1,  0, 0, 0,        2'b00, 0, 0,         0, 0,         2'b00, 0,  0, 1, 32'h1234,  0);
        v(1, 6, 5, 10,0,  1, 6, 32'hCAFE, 2'b00, 0, 0,         0, 0,         2'b00, 0,  0, 1, 32'hCAFE,  32'h1234);
        v(1, 6, 7, 11,1,  0, 0, 0,        2'b00, 0, 0,         0, 0,         2'b00, 0,  0, 1, 32'hCAFE,  0);
        v(1, 7, 7, 12,0,  0, 0, 0,        2'b11, 7, 32'hAAAA,  7, 32'hBBBB,  2'b00, 0,  0, 1, 32'hAAAA,  32'hAAAA);
        v(1, 7, 6, 13,1,  0, 0, 0,        2'b10, 7, 32'hAAAA,  7, 32'hBBBB,  2'b00, 0,  0, 1, 32'hBBBB,  32'hCAFE);
        v(1, 8, 8, 14,0,  1, 8, 32'h22,   2'b01, 8, 32'h11,    0, 0,         2'b00, 0,  0, 1, 32'h11,    32'h11);
        v(1, 8, 0, 15,1,  0, 0, 0,        2'b00, 0, 0,         0, 0,         2'b00, 0,  0, 1, 32'h22,    0);
        v(1, 0, 0, 16,0,  1, 0, 32'hFFFF, 2'b01, 0, 32'h77,    0, 0,         2'b00, 0,  0, 1, 0,         0);
        v(1, 0, 5, 17,1,  0, 0, 0,        2'b01, 0, 32'h99,    0, 0,         2'b01, 0,  0, 1, 0,         32'h1234);
        v(1, 5, 3, 18,0,  0, 0, 0,        2'b01, 3, 32'hDEAD,  0, 0,         2'b01, 0,  1, 0, 0,         0);
        v(1, 5, 3, 18,0,  0, 0, 0,        2'b10, 0, 0,         3, 32'h55,    2'b00, 0,  0, 1, 32'h1234,  32'h55);
        v(1, 4, 0, 19,1,  0, 0, 0,        2'b11, 4, 32'h66,    4, 32'h88,    2'b10, 0,  0, 1, 32'h66,    0);
        v(1, 4, 0, 20,1,  0, 0, 0,        2'b10, 0, 0,         4, 32'h88,    2'b10, 0,  1, 0, 0,         0);
        v(1, 4, 0, 20,1,  0, 0, 0,        2'b10, 0, 0,         4, 32'h88,    2'b10, 1,  0, 0, 0,         0);
        v(0, 4, 0, 20,1,  0, 0, 0,        2'b10, 0, 0,         4, 32'h88,    2'b10, 0,  0, 0, 0,         0);
        v(1, 5, 5, 21,1,  0, 0, 0,        2'b00, 0, 0,         0, 0,         2'b00, 1,  0, 0, 0,         0);
        v(1, 4, 5, 22,0,  0, 0, 0,        2'b10, 0, 0,         4, 32'h88,    2'b00, 0,  0, 1, 32'h88,    32'h1234);

        #3;
        chk("reset_valid", out_valid, 0);
        chk("reset_da", out_da, 0);
        chk("reset_db", out_db, 0);
        chk("reset_ctrl", out_ctrl, 0);
        chk("reset_wr", out_wr_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t x;
            x = vecs[i];
            low = 11'(i * 13 + 1);
            ctl = 12'(i * 37 + 5);
            @(negedge clk);
            in_valid = x.iv;
            inst     = {6'h23, x.rs, x.rt, x.rd, low};
            ctrl_in  = ctl;
            reg_dst  = x.rdst;
            wb_en = x.wbe; wb_addr = x.wba; wb_data = x.wbd;
            fwd_en = x.fe; fwd_addr = {x.fa1, x.fa0}; fwd_data = {x.fd1, x.fd0};
            fwd_load = x.fl; flush = x.fsh;
            #1;
            chk($sformatf("v%0d_stall", i), stall, x.e_stall);
            @(posedge clk);
            #1;
            if (x.e_valid) begin
                h_da = x.e_da; h_db = x.e_db; h_imm = {x.rd, low};
                h_rt = x.rt; h_wr = x.rdst ? x.rd : x.rt; h_ctrl = ctl;
            end
            chk($sformatf("v%0d_valid", i), out_valid, x.e_valid);
            chk($sformatf("v%0d_da", i), out_da, h_da);
            chk($sformatf("v%0d_db", i), out_db, h_db);
            chk($sformatf("v%0d_imm", i), out_imm16, h_imm);
            chk($sformatf("v%0d_rt", i), out_rt, h_rt);
            chk($sformatf("v%0d_wr", i), out_wr_addr, h_wr);
            chk($sformatf("v%0d_ctrl", i), out_ctrl, h_ctrl);
            $display("vec %0d: stall=%0b valid=%0b da=0x%0h db=0x%0h wr=%0d",
                     i, stall, out_valid, out_da, out_db, out_wr_addr);
        end

        // Asynchronous reset in the middle of a stalled cycle.
        @(negedge clk);
        idle_inputs();
        in_valid = 1; inst = {6'h23, 5'd5, 5'd3, 5'd1, 11'd0};
        fwd_en = 2'b01; fwd_addr = {5'd0, 5'd3}; fwd_load = 2'b01;
        #1;
        chk("rst_pre_stall", stall, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_da", out_da, 0);
        chk("rst_async_db", out_db, 0);
        chk("rst_async_imm", out_imm16, 0);
        chk("rst_async_rt", out_rt, 0);
        chk("rst_async_wr", out_wr_addr, 0);
        chk("rst_async_ctrl", out_ctrl, 0);
        chk("rst_stall_comb", stall, 1);
        $display("mid-stream reset: valid=%0b da=0x%0h stall=%0b", out_valid, out_da, stall);

        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        in_valid = 1; inst = {6'h23, 5'd5, 5'd6, 5'd2, 11'd0}; reg_dst = 1;
        #1;
        chk("post_rst_stall", stall, 0);
        @(posedge clk);
        #1;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_r5", out_da, 0);
        chk("post_rst_r6", out_db, 0);
        chk("post_rst_wr", out_wr_addr, 2);
        $display("post reset read: valid=%0b r5=0x%0h r6=0x%0h", out_valid, out_da, out_db);

        @(negedge clk);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
